// File: rtl/difftest_pkg.sv
// Shared difftest types: the retire-entry record and the width constants
// used by the commit queue and its storage.
package difftest_pkg;

    localparam int XLEN    = 64;  // PC and data width
    localparam int ILEN    = 32;  // instruction word width
    localparam int DEST_W  = 8;   // GPR destination width
    localparam int INDEX_W = 8;   // commit sequence counter width
    localparam int COUNT_W = 7;   // occupancy width, holds 0..64

    // One retired instruction or one exception/interrupt/mret event.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [ILEN-1:0]   instr;
        logic              skip;
        logic              wen;
        logic [DEST_W-1:0] wdest;
        logic [XLEN-1:0]   wdata;
        logic              excp;
        logic              isMret;
        logic [31:0]       intrptNo;
        logic [31:0]       cause;
    } entry_t;

endpackage

// File: rtl/diff_fifo_mem.sv
// Entry storage for the commit queue: one synchronous write port and one
// combinational read port, so the top can register the head directly.
module diff_fifo_mem
    import difftest_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          wen,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    // Write port: store the offered entry at the tail slot.
    // NOTE: the array has no reset; validity is tracked by the pointers, and
    // a reset here would turn the array into flops instead of RAM.
    always_ff @(posedge clock) begin
        if (wen) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/diff_commit_queue.sv
// Difftest commit queue: buffers retired entries in FIFO order and replays
// them through a registered output stage as commit or event pulses.
module diff_commit_queue
    import difftest_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [ILEN-1:0]    in_instr,
    input  logic               in_skip,
    input  logic               in_wen,
    input  logic [DEST_W-1:0]  in_wdest,
    input  logic [XLEN-1:0]    in_wdata,
    input  logic               in_excp,
    input  logic               in_isMret,
    input  logic [31:0]        in_intrptNo,
    input  logic [31:0]        in_cause,
    input  logic               drain_en,
    input  logic               flush,
    output logic               instrValid,
    output logic [INDEX_W-1:0] index,
    output logic [XLEN-1:0]    the_pc,
    output logic [ILEN-1:0]    instr,
    output logic               skip,
    output logic               wen,
    output logic [DEST_W-1:0]  wdest,
    output logic [XLEN-1:0]    wdata,
    output logic               excp_valid,
    output logic               isMret,
    output logic [31:0]        intrptNo,
    output logic [31:0]        cause,
    output logic [XLEN-1:0]    exceptionPC,
    output logic [ILEN-1:0]    exceptionInst,
    output logic [COUNT_W-1:0] count,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]        wr_ptr, rd_ptr;
    logic [AW:0]        occupancy;
    logic               full, empty;
    logic               push, pop;
    logic [INDEX_W-1:0] commit_seq;
    entry_t             in_entry;
    entry_t             head;

    assign occupancy = wr_ptr - rd_ptr;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign count     = COUNT_W'(occupancy);
    assign in_ready  = !full;

    // Flush wins over both ports in the same edge.
    assign push = in_valid && !full && !flush;
    assign pop  = drain_en && !empty && !flush;

    // Gather the input ports into one storage record.
    always_comb begin
        in_entry          = '0;
        in_entry.pc       = in_pc;
        in_entry.instr    = in_instr;
        in_entry.skip     = in_skip;
        in_entry.wen      = in_wen;
        in_entry.wdest    = in_wdest;
        in_entry.wdata    = in_wdata;
        in_entry.excp     = in_excp;
        in_entry.isMret   = in_isMret;
        in_entry.intrptNo = in_intrptNo;
        in_entry.cause    = in_cause;
    end

    diff_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .wen   (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_entry),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (head)
    );

    // Pointer update: flush rewinds both, otherwise advance on push/pop.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Sticky overflow: any offer while full is a dropped entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (in_valid && full) begin
            overflow <= 1'b1;
        end
    end

    // Output stage: one-cycle pulse per popped entry, data held between pops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instrValid    <= 1'b0;
            excp_valid    <= 1'b0;
            commit_seq    <= '0;
            index         <= '0;
            the_pc        <= '0;
            instr         <= '0;
            skip          <= 1'b0;
            wen           <= 1'b0;
            wdest         <= '0;
            wdata         <= '0;
            isMret        <= 1'b0;
            intrptNo      <= '0;
            cause         <= '0;
            exceptionPC   <= '0;
            exceptionInst <= '0;
        end else begin
            instrValid <= 1'b0;
            excp_valid <= 1'b0;
            if (pop) begin
                if (head.excp) begin
                    excp_valid    <= 1'b1;
                    isMret        <= head.isMret;
                    intrptNo      <= head.intrptNo;
                    cause         <= head.cause;
                    exceptionPC   <= head.pc;
                    exceptionInst <= head.instr;
                end else begin
                    instrValid <= 1'b1;
                    index      <= commit_seq;
                    commit_seq <= commit_seq + 1'b1;
                    the_pc     <= head.pc;
                    instr      <= head.instr;
                    skip       <= head.skip;
                    wen        <= head.wen;
                    wdest      <= head.wdest;
                    wdata      <= head.wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_diff_commit_queue.sv
// Scoreboard bench for diff_commit_queue: stimulus pushes expected pulses,
// a negedge monitor pops and compares every valid pulse.
module tb_diff_commit_queue;
    import difftest_pkg::*;

    typedef struct {
        bit          is_commit;
        logic [7:0]  idx;
        logic [63:0] pc;
        logic [31:0] instr;
        logic        skip;
        logic        wen;
        logic [7:0]  wdest;
        logic [63:0] wdata;
        logic        is_mret;
        logic [31:0] intrpt;
        logic [31:0] cause;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [63:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_skip = 1'b0, in_wen = 1'b0;
    logic [7:0]  in_wdest = '0;
    logic [63:0] in_wdata = '0;
    logic        in_excp = 1'b0, in_isMret = 1'b0;
    logic [31:0] in_intrptNo = '0, in_cause = '0;
    logic        drain_en = 1'b0, flush = 1'b0;
    logic        instrValid, skip, wen, excp_valid, isMret, overflow;
    logic [7:0]  index, wdest;
    logic [63:0] the_pc, wdata, exceptionPC;
    logic [31:0] instr, intrptNo, cause, exceptionInst;
    logic [6:0]  count;

    int         n_checks = 0;
    int         n_fail   = 0;
    exp_t       exp_q[$];
    logic [7:0] exp_seq = '0;

    always #5 clock = ~clock;

    diff_commit_queue #(.DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_skip(in_skip),
        .in_wen(in_wen), .in_wdest(in_wdest), .in_wdata(in_wdata),
        .in_excp(in_excp), .in_isMret(in_isMret),
        .in_intrptNo(in_intrptNo), .in_cause(in_cause),
        .drain_en(drain_en), .flush(flush),
        .instrValid(instrValid), .index(index), .the_pc(the_pc),
        .instr(instr), .skip(skip), .wen(wen), .wdest(wdest), .wdata(wdata),
        .excp_valid(excp_valid), .isMret(isMret), .intrptNo(intrptNo),
        .cause(cause), .exceptionPC(exceptionPC), .exceptionInst(exceptionInst),
        .count(count), .overflow(overflow)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one entry for one edge; optionally record the pulse it must produce.
    task automatic push_one(input bit is_excp, input logic [63:0] pc, input logic [31:0] ins,
                            input logic w, input logic [7:0] dest, input logic [63:0] data,
                            input logic [31:0] cs, input bit expect_out);
        exp_t e;
        in_valid = 1'b1; in_excp = is_excp; in_pc = pc; in_instr = ins;
        in_skip = 1'b0; in_wen = w; in_wdest = dest; in_wdata = data;
        in_isMret = 1'b0; in_intrptNo = '0; in_cause = cs;
        if (expect_out) begin
            e = '{is_commit: !is_excp, idx: exp_seq, pc: pc, instr: ins, skip: 1'b0,
                  wen: w, wdest: dest, wdata: data, is_mret: 1'b0, intrpt: '0, cause: cs};
            exp_q.push_back(e);
            if (!is_excp) exp_seq++;
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        exp_seq = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic expect_drained(input string name);
        @(posedge clock); @(negedge clock); #1;
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (reset && (instrValid || excp_valid)) begin
            check("both_valids", 64'(instrValid && excp_valid), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'(instrValid | excp_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("instrValid", 64'(instrValid), 64'(e.is_commit));
                check("excp_valid", 64'(excp_valid), 64'(!e.is_commit));
                if (e.is_commit) begin
                    check("index", 64'(index), 64'(e.idx));
                    check("the_pc", the_pc, e.pc);
                    check("instr", 64'(instr), 64'(e.instr));
                    check("wen", 64'(wen), 64'(e.wen));
                    check("wdest", 64'(wdest), 64'(e.wdest));
                    check("wdata", wdata, e.wdata);
                end else begin
                    check("cause", 64'(cause), 64'(e.cause));
                    check("exceptionPC", exceptionPC, e.pc);
                    check("exceptionInst", 64'(exceptionInst), 64'(e.instr));
                    check("isMret", 64'(isMret), 64'(e.is_mret));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("rst_instrValid", 64'(instrValid), 64'd0);
        check("rst_the_pc", the_pc, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        @(posedge clock); #1 reset = 1'b1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single commit, one-edge latency, then hold
        drain_en = 1'b1;
        push_one(0, 64'h8000_0000, 32'h0000_0413, 1, 8'd8, 64'd0, 0, 1);
        check("lat_not_yet", 64'(instrValid), 64'd0);
        @(posedge clock); #1;
        check("lat_pulse", 64'(instrValid), 64'd1);
        @(posedge clock); #1;
        check("pulse_one_cycle", 64'(instrValid), 64'd0);
        check("hold_pc", the_pc, 64'h8000_0000);
        expect_drained("single_drained");

        // Fill, overflow, drain
        do_reset();
        drain_en = 1'b0;
        for (int i = 0; i < 8; i++)
            push_one(0, 64'h8000_0100 + 64'(4 * i), 32'h13 + 32'(i), 1, 8'(i + 1), 64'(100 + i), 0, 1);
        check("full_count", 64'(count), 64'd8);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_no_ovf", 64'(overflow), 64'd0);
        push_one(0, 64'hdead_beef, 32'hbad, 1, 8'd31, 64'hbad, 0, 0);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_count", 64'(count), 64'd8);
        drain_en = 1'b1;
        repeat (8) @(posedge clock);
        @(negedge clock); #1;
        check("drain_sb_empty", 64'(exp_q.size()), 64'd0);
        check("drain_count", 64'(count), 64'd0);
        repeat (3) @(posedge clock);
        #1 check("empty_no_pulse", 64'(instrValid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);

        // Index wrap with continuous streaming
        do_reset();
        drain_en = 1'b1;
        for (int i = 0; i < 259; i++)
            push_one(0, 64'h1000 + 64'(4 * i), 32'(i), 1, 8'(i), 64'(i * 3), 0, 1);
        expect_drained("wrap_no_gap");
        check("wrap_last_idx", 64'(index), 64'd2);

        // Commit, event, commit
        do_reset();
        drain_en = 1'b1;
        push_one(0, 64'h8000_0008, 32'h0010_0093, 1, 8'd1, 64'd1, 0, 1);
        push_one(1, 64'h8000_0010, 32'h0000_0073, 0, 8'd0, 64'd0, 32'd11, 1);
        push_one(0, 64'h8000_0014, 32'h0020_0113, 1, 8'd2, 64'd2, 0, 1);
        expect_drained("mixed_drained");
        check("mixed_last_idx", 64'(index), 64'd1);

        // Flush with concurrent push and drain
        drain_en = 1'b0;
        for (int i = 0; i < 5; i++)
            push_one(0, 64'h9000_0000 + 64'(4 * i), 32'h13, 0, 8'd0, 64'd0, 0, 0);
        check("pre_flush_count", 64'(count), 64'd5);
        flush = 1'b1; drain_en = 1'b1;
        push_one(0, 64'h9999_0000, 32'h13, 0, 8'd0, 64'd0, 0, 0);
        flush = 1'b0;
        check("flush_count", 64'(count), 64'd0);
        check("flush_no_pulse", 64'(instrValid), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        push_one(0, 64'h8000_0200, 32'h0030_0193, 1, 8'd3, 64'd3, 0, 1);
        expect_drained("post_flush_idx2");
        check("post_flush_index", 64'(index), 64'd2);

        // Reset mid-drain
        drain_en = 1'b0;
        for (int i = 0; i < 4; i++)
            push_one(0, 64'ha000_0000 + 64'(4 * i), 32'h13, 1, 8'd5, 64'(i), 0, 1);
        drain_en = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        reset = 1'b0; drain_en = 1'b0;
        #1;
        check("mid_rst_instrValid", 64'(instrValid), 64'd0);
        check("mid_rst_the_pc", the_pc, 64'd0);
        check("mid_rst_index", 64'(index), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_sb_left", 64'(exp_q.size()), 64'd2);
        exp_q.delete();
        exp_seq = '0;
        @(posedge clock); #1 reset = 1'b1;
        drain_en = 1'b1;
        push_one(0, 64'h8000_0000, 32'h0000_0413, 1, 8'd8, 64'd7, 0, 1);
        expect_drained("after_rst_drained");
        check("after_rst_index", 64'(index), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/diff_commit_queue.md
DIFF_COMMIT_QUEUE -- requirements
Module: diff_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, entry count (power of two, 2..64).
REQ-002 SHALL have ports: clock  in  1  sole clock, rising edge; reset  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: in_valid  in  1  retire entry offered; in_ready  out  1  entry accepted this edge when both high.
REQ-004 SHALL have ports: in_pc  in  64  retired PC; in_instr  in  32  instruction word; in_skip  in  1  reference model skips check.
REQ-005 SHALL have ports: in_wen  in  1  GPR write; in_wdest  in  8  destination; in_wdata  in  64  written value.
REQ-006 SHALL have ports: in_excp  in  1  entry is exception/interrupt/mret event, not a commit; in_isMret  in  1; in_intrptNo  in  32; in_cause  in  32.
REQ-007 SHALL have ports: drain_en  in  1  permits pop; flush  in  1  synchronous discard of all entries.
REQ-008 SHALL have commit outputs: instrValid  out  1; index  out  8; the_pc  out  64; instr  out  32; skip  out  1; wen  out  1; wdest  out  8; wdata  out  64.
REQ-009 SHALL have event outputs: excp_valid  out  1; isMret  out  1; intrptNo  out  32; cause  out  32; exceptionPC  out  64; exceptionInst  out  32.
REQ-010 SHALL have status outputs: count  out  7  occupancy; overflow  out  1  sticky, push attempted while full.

Function
REQ-011 SHALL store entries in FIFO order, circular buffer with read/write pointers one bit wider than log2(DEPTH).
REQ-012 SHALL drive in_ready = !full, combinationally from registered state only; no full-bypass.
REQ-013 SHALL pop the head at a rising edge when drain_en=1 and not empty, loading it into registered output stage.
REQ-014 SHALL give latency of exactly one edge: entry pushed at edge N into an empty queue, with drain_en high, appears on outputs after edge N+1.
REQ-015 SHALL hold instrValid/excp_valid high for exactly one cycle per popped entry; low on any cycle without a pop.
REQ-016 SHALL, for a commit entry (in_excp=0), assert instrValid with index = commit sequence counter, then increment counter modulo 256.
REQ-017 SHALL, for an event entry (in_excp=1), assert excp_valid only, map exceptionPC=pc and exceptionInst=instr, and not increment the counter.
REQ-018 SHALL never assert instrValid and excp_valid in the same cycle.
REQ-019 SHALL hold all data outputs at last popped values when no pop occurs.
REQ-020 SHALL accept simultaneous push and pop in one edge when not full; count unchanged.
REQ-021 SHALL, on empty with drain_en=1, produce no pop and keep valids low.
REQ-022 SHALL, on flush, clear pointers and count at the next edge, ignore same-edge push, suppress same-edge pop, keep the index counter.
REQ-023 SHALL set overflow when in_valid=1 and full; cleared only by reset.

Reset
REQ-024 SHALL, on reset low, immediately clear pointers, count, index counter, overflow, instrValid, excp_valid and all data outputs to zero; in_ready=1 after release.
REQ-025 SHALL discard in-flight entries on mid-operation reset; first commit after release carries index 0.

Structure
REQ-026 SHALL take the entry record type (pc, instr, skip, wen, wdest, wdata, excp, isMret, intrptNo, cause) and the index width constant (8) from a shared difftest package.
REQ-027 SHALL implement storage as one sub-module diff_fifo_mem (DEPTH x entry, one write port, one read port); control and output stage in the top.

Verification
REQ-028 Single push pc=0x80000000, instr=0x00000413, wen=1, wdest=8, wdata=0, drain_en=1 -> one instrValid pulse one edge later, index=0, same fields.
REQ-029 Push 8 commits with drain_en=0 -> count=8, in_ready=0; 9th push -> overflow=1, entry dropped; raise drain_en -> 8 consecutive pulses, index 0..7, 9th data absent.
REQ-030 Push 256+3 commits continuously with drain_en=1 -> index wraps 255->0, last three indices 0,1,2, no gap cycles.
REQ-031 Push commit, event (in_excp=1, cause=11, pc=0x80000010), commit -> instrValid idx0, excp_valid cause=11 exceptionPC=0x80000010, instrValid idx1 on three consecutive cycles.
REQ-032 Fill 5 entries, flush with concurrent push -> count=0 next edge, no valid pulses, next commit carries index of next sequence number.
REQ-033 Assert reset mid-drain with 4 entries queued -> outputs zero immediately, count=0; after release first commit index=0.
